// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode constants and the fetch FSM encoding.
//   CPU_ADDR_W / CPU_DATA_W : default instruction word-address / data widths
//   OP_*                    : opcode values found in inst[31:28]
//   fetch_state_t           : instruction fetch FSM states
package cpu_pkg;
  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 32;

  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: valid/ready output stage between fetch and decode.
//   clk, rst_n          : clock, async active-low reset (clears valid and data)
//   load                : capture in_inst/in_pc and mark valid
//   flush               : drop the held word (wins over load and accept)
//   out_ready           : downstream accept; clears valid when nothing loads
//   in_inst, in_pc      : word and its address to capture
//   out_valid/inst/pc   : registered output
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_inst,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc
);
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      inst_d  = in_inst;
      pc_d    = in_pc;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_inst  = inst_q;
  assign out_pc    = pc_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC + fetch FSM driving an async-read instruction memory.
//   clk, rst_n         : clock, async active-low reset
//   start              : leave IDLE and begin fetching at the current PC
//   inst_address       : word address to memory (always the PC)
//   read_data          : combinational memory data for inst_address
//   redirect_valid/tgt : branch/jump; flushes output and reloads PC (not in IDLE)
//   out_valid/ready    : handshake to decode; out_inst/out_pc carry the word
//   halted             : high while in HALT
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = CPU_ADDR_W,
  parameter int              DATA_W   = CPU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OP  = OP_HALT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] inst_address,
  input  logic [DATA_W-1:0] read_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);
  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              load, flush;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    // Redirect outranks everything once running; the redirect cycle never
    // loads, which is what produces the single bubble.
    if (redirect_valid && state_q != ST_IDLE) begin
      flush   = 1'b1;
      pc_d    = redirect_target;
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_FETCH;
        ST_FETCH: begin
          if (!out_valid || out_ready) begin
            load = 1'b1;
            pc_d = pc_q + 1'b1;
            // Halt word is still delivered; only further fetches stop.
            if (read_data[DATA_W-1 -: 4] == HALT_OP) state_d = ST_HALT;
          end
        end
        ST_HALT: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .flush    (flush),
    .out_ready(out_ready),
    .in_inst  (read_data),
    .in_pc    (pc_q),
    .out_valid(out_valid),
    .out_inst (out_inst),
    .out_pc   (out_pc)
  );

  assign inst_address = pc_q;
  assign halted       = (state_q == ST_HALT);
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] inst_address;
  logic [DW-1:0] read_data;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_target = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_inst;
  logic [AW-1:0] out_pc;
  logic          halted;

  logic [DW-1:0] mem [0:65535];
  assign read_data = mem[inst_address];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: mode 0=idle 1=fetching 2=halted
  int            m_mode;
  logic [AW-1:0] m_pc, m_opc;
  logic [DW-1:0] m_inst;
  logic          m_valid;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(16'h0000), .HALT_OP(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inst_address(inst_address),
    .read_data(read_data), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .halted(halted)
  );

  task automatic model_reset();
    m_mode = 0; m_pc = '0; m_opc = '0; m_inst = '0; m_valid = 1'b0;
  endtask

  // advance one clock, updating the model from the inputs seen at the edge
  task automatic step();
    int            n_mode  = m_mode;
    logic [AW-1:0] n_pc    = m_pc;
    logic [AW-1:0] n_opc   = m_opc;
    logic [DW-1:0] n_inst  = m_inst;
    logic          n_valid = m_valid;
    if (m_mode == 0) begin
      if (start) n_mode = 1;
    end else if (redirect_valid) begin
      n_pc = redirect_target; n_valid = 1'b0; n_mode = 1;
    end else if (m_mode == 1) begin
      if (!m_valid || out_ready) begin
        n_inst = mem[m_pc]; n_opc = m_pc; n_valid = 1'b1;
        n_pc = m_pc + 16'd1;
        if (mem[m_pc][31:28] == 4'hF) n_mode = 2;
      end
    end else begin
      if (m_valid && out_ready) n_valid = 1'b0;
    end
    @(posedge clk);
    m_mode = n_mode; m_pc = n_pc; m_opc = n_opc; m_inst = n_inst; m_valid = n_valid;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    start = 0; redirect_valid = 0; out_ready = 0;
    rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if ({out_valid, halted, out_inst, out_pc, inst_address} !== {2'b00, 32'h0, 16'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_vals: valid=%b halt=%b inst=%h pc=%h addr=%h, want all zero",
               out_valid, halted, out_inst, out_pc, inst_address);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(); step();
    n_checks++;
    if (out_valid !== 1'b0 || inst_address !== 16'h0) begin
      n_fail++;
      $display("FAIL idle_no_fetch: valid=%b addr=%h, want 0/0000", out_valid, inst_address);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp_w [4];
    exp_w[0] = 32'h2000_0004; exp_w[1] = 32'h1111_0000;
    exp_w[2] = 32'h2222_0000; exp_w[3] = 32'hF000_0000;
    for (int i = 0; i < 4; i++) mem[i] = exp_w[i];
    out_ready = 1; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 16'(i) || out_inst !== exp_w[i]) begin
        n_fail++;
        $display("FAIL stream_%0d: valid=%b pc=%h inst=%h, want 1 %h %h",
                 i, out_valid, out_pc, out_inst, 16'(i), exp_w[i]);
      end
    end
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_assert: halted=%b want 1", halted);
    end
    start = 1;  // must be ignored in HALT
    step();
    start = 0;
    n_checks++;
    if (halted !== 1'b1 || out_valid !== 1'b0 || inst_address !== 16'h4) begin
      n_fail++;
      $display("FAIL halt_state: halted=%b valid=%b addr=%h, want 1 0 0004",
               halted, out_valid, inst_address);
    end
  endtask

  task automatic test_stall();
    mem[16'h40] = 32'h3333_0040;
    redirect_valid = 1; redirect_target = 16'h0000; out_ready = 1;
    step();
    redirect_valid = 0;
    step(); step();  // out_pc 0, then 1
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 16'h1 || out_inst !== 32'h1111_0000 ||
          inst_address !== 16'h2) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: valid=%b pc=%h inst=%h addr=%h, want 1 0001 11110000 0002",
                 i, out_valid, out_pc, out_inst, inst_address);
      end
    end
    out_ready = 1;
    step();
    n_checks++;
    if (out_pc !== 16'h2 || out_inst !== 32'h2222_0000) begin
      n_fail++;
      $display("FAIL stall_resume: pc=%h inst=%h, want 0002 22220000", out_pc, out_inst);
    end
    out_ready = 0;
    redirect_valid = 1; redirect_target = 16'h0040;
    step();
    redirect_valid = 0;
    n_checks++;
    if (out_valid !== 1'b0 || inst_address !== 16'h0040) begin
      n_fail++;
      $display("FAIL redirect_bubble: valid=%b addr=%h, want 0 0040", out_valid, inst_address);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 16'h0040 || out_inst !== 32'h3333_0040) begin
      n_fail++;
      $display("FAIL redirect_target: valid=%b pc=%h inst=%h, want 1 0040 33330040",
               out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 32'h5555_FFFF;
    out_ready = 1; redirect_valid = 1; redirect_target = 16'hFFFF;
    step();
    redirect_valid = 0;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 16'hFFFF || out_inst !== 32'h5555_FFFF) begin
      n_fail++;
      $display("FAIL wrap_top: valid=%b pc=%h inst=%h, want 1 ffff 5555ffff", out_valid, out_pc, out_inst);
    end
    step();
    n_checks++;
    if (out_pc !== 16'h0000 || out_inst !== 32'h2000_0004 || inst_address !== 16'h0001) begin
      n_fail++;
      $display("FAIL wrap_zero: pc=%h inst=%h addr=%h, want 0000 20000004 0001",
               out_pc, out_inst, inst_address);
    end
  endtask

  task automatic test_halt_redirect();
    mem[16'h10] = 32'h7777_0010;
    out_ready = 1; redirect_valid = 1; redirect_target = 16'h0003;
    step();
    redirect_valid = 0;
    step(); step();
    n_checks++;
    if (halted !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_again: halted=%b valid=%b, want 1 0", halted, out_valid);
    end
    redirect_valid = 1; redirect_target = 16'h0010;
    step();
    redirect_valid = 0;
    n_checks++;
    if (halted !== 1'b0 || out_valid !== 1'b0 || inst_address !== 16'h0010) begin
      n_fail++;
      $display("FAIL halt_redirect: halted=%b valid=%b addr=%h, want 0 0 0010",
               halted, out_valid, inst_address);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 16'h0010 || out_inst !== 32'h7777_0010) begin
      n_fail++;
      $display("FAIL halt_resume: valid=%b pc=%h inst=%h, want 1 0010 77770010",
               out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h1000_0000 | 32'(i);
    do_reset();
    out_ready = 1; start = 1;
    step();
    start = 0;
    while (!(m_pc == 16'd5 && m_valid) && guard < 20) begin
      step(); guard++;
    end
    n_checks++;
    if (out_valid !== 1'b1 || inst_address !== 16'd5 || out_pc !== 16'd4) begin
      n_fail++;
      $display("FAIL mid_setup: valid=%b addr=%h pc=%h, want 1 0005 0004", out_valid, inst_address, out_pc);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || inst_address !== 16'h0 || out_pc !== 16'h0 || out_inst !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b addr=%h pc=%h inst=%h, want 0 0000 0000 0",
               out_valid, inst_address, out_pc, out_inst);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (out_valid !== 1'b0 || inst_address !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_idle: valid=%b addr=%h, want 0 0000", out_valid, inst_address);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int c = 0; c < 600; c++) begin
      start          = ($urandom_range(0, 9) < 2);
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_target = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                                                     : 16'($urandom_range(0, 255));
      step();
      n_checks++;
      if (out_valid !== m_valid || halted !== (m_mode == 2) || inst_address !== m_pc ||
          out_pc !== m_opc || out_inst !== m_inst) begin
        n_fail++;
        $display("FAIL rand_%0d: got v=%b h=%b a=%h pc=%h i=%h, want v=%b h=%b a=%h pc=%h i=%h",
                 c, out_valid, halted, inst_address, out_pc, out_inst,
                 m_valid, (m_mode == 2), m_pc, m_opc, m_inst);
      end
    end
    redirect_valid = 0; start = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h1000_0000 | 32'(i);
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_wrap();
    test_halt_redirect();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
